// File: rtl/bubble_pkg.sv
// Shared types and constants for the bubble memory channel engine.
// Holds the FSM state encoding, the position width and the lane-count ceiling.
package bubble_pkg;

  localparam int unsigned POS_W        = 12;
  localparam int unsigned MAX_CHANNELS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StReadout,
    StStop
  } bubble_state_e;

  // Address width for a page of n entries; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bubble_channel_engine_if.sv
// Host page-write bus for the bubble channel engine.
// The host side drives writes and commits; the engine side consumes them.
interface bubble_channel_engine_if
  import bubble_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned PAGE_BITS = 584
);

  localparam int unsigned AW = addr_width(PAGE_BITS);

  logic [AW-1:0]       wr_addr;
  logic [CHANNELS-1:0] wr_data;
  logic                wr_en;
  logic                wr_commit;

  modport master (
    output wr_addr,
    output wr_data,
    output wr_en,
    output wr_commit
  );

  modport slave (
    input wr_addr,
    input wr_data,
    input wr_en,
    input wr_commit
  );

endinterface

// File: rtl/bubble_page_bank.sv
// Ping-pong page storage: host fills one bank while the other is read out.
// Optional bootloader bank when BUBBLE_BOOTLOOP_EN is defined.
module bubble_page_bank
  import bubble_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned PAGE_BITS = 584,
  localparam int unsigned AW       = addr_width(PAGE_BITS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
`ifdef BUBBLE_BOOTLOOP_EN
  input  logic                 bootloop_enable_i,
`endif
  bubble_channel_engine_if.slave host,
  input  logic                 rd_start_i,
  input  logic                 rd_release_i,
  input  logic [AW-1:0]        rd_addr_i,
  output logic                 rd_avail_o,
  output logic [CHANNELS-1:0]  rd_data_o
);

  logic [CHANNELS-1:0] bank0_mem [PAGE_BITS];
  logic [CHANNELS-1:0] bank1_mem [PAGE_BITS];

  logic fill_q, fill_d;
  logic valid_q, valid_d;
  logic reading_q, reading_d;
  logic pend_q, pend_d;
  logic rd_bank_q, rd_bank_d;
  logic in_range, use_boot, bank_busy, do_swap;

  assign in_range = 32'(host.wr_addr) < PAGE_BITS;

`ifdef BUBBLE_BOOTLOOP_EN
  logic [CHANNELS-1:0] boot_mem [PAGE_BITS];
  logic                rd_boot_q;

  assign use_boot   = bootloop_enable_i;
  assign rd_avail_o = valid_q | bootloop_enable_i;
  assign rd_data_o  = rd_boot_q ? boot_mem[rd_addr_i] :
                      rd_bank_q ? bank1_mem[rd_addr_i] : bank0_mem[rd_addr_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_boot_q <= 1'b0;
    end else if (rd_start_i) begin
      rd_boot_q <= bootloop_enable_i;
    end
  end
`else
  assign use_boot   = 1'b0;
  assign rd_avail_o = valid_q;
  assign rd_data_o  = rd_bank_q ? bank1_mem[rd_addr_i] : bank0_mem[rd_addr_i];
`endif

  // The committed bank is locked while a readout holds it; a release frees it
  // in the same cycle so a coincident commit swaps immediately.
  assign bank_busy = (reading_q && !rd_release_i) || (rd_start_i && valid_q && !use_boot);
  assign do_swap   = (host.wr_commit || pend_q) && !bank_busy;

  always_comb begin
    fill_d    = fill_q;
    valid_d   = valid_q;
    reading_d = reading_q;
    pend_d    = pend_q;
    rd_bank_d = rd_bank_q;
    if (rd_release_i) begin
      reading_d = 1'b0;
    end
    if (rd_start_i) begin
      rd_bank_d = ~fill_q;
      reading_d = valid_q && !use_boot;
    end
    if (do_swap) begin
      fill_d  = ~fill_q;
      valid_d = 1'b1;
      pend_d  = 1'b0;
    end else if (host.wr_commit) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q    <= 1'b0;
      valid_q   <= 1'b0;
      reading_q <= 1'b0;
      pend_q    <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      fill_q    <= fill_d;
      valid_q   <= valid_d;
      reading_q <= reading_d;
      pend_q    <= pend_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Page RAM is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (host.wr_en && in_range) begin
`ifdef BUBBLE_BOOTLOOP_EN
      if (use_boot) begin
        boot_mem[host.wr_addr] <= host.wr_data;
      end else if (fill_q) begin
        bank1_mem[host.wr_addr] <= host.wr_data;
      end else begin
        bank0_mem[host.wr_addr] <= host.wr_data;
      end
`else
      if (fill_q) begin
        bank1_mem[host.wr_addr] <= host.wr_data;
      end else begin
        bank0_mem[host.wr_addr] <= host.wr_data;
      end
`endif
    end
  end

endmodule

// File: rtl/bubble_channel_engine.sv
// Bubble memory channel engine: coil shift timing, position tracking and page readout.
// Define BUBBLE_BOOTLOOP_EN to add the bootloop_enable port and bootloader bank.
module bubble_channel_engine
  import bubble_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned POSITIONS = 2053,
  parameter int unsigned PAGE_BITS = 584,
  parameter int unsigned SHIFT_DIV = 48
) (
  input  logic                master_clock,
  input  logic                reset_n,
  input  logic                power_good,
  input  logic                bubble_shift_enable,
  input  logic                replicator_enable,
`ifdef BUBBLE_BOOTLOOP_EN
  input  logic                bootloop_enable,
`endif
  bubble_channel_engine_if.slave host,
  output logic [CHANNELS-1:0] bubble_out,
  output logic [POS_W-1:0]    position,
  output logic                load_page,
  output logic                busy,
  output logic                underrun
);

  localparam int unsigned SW = $clog2(SHIFT_DIV);
  localparam int unsigned AW = addr_width(PAGE_BITS);

  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS || SHIFT_DIV < 4) begin : g_bad_params
    $error("bubble_channel_engine: CHANNELS or SHIFT_DIV out of range");
  end

  logic [1:0] shift_sync_q, rep_sync_q;
  logic       shift_prev_q, rep_prev_q;
  logic       shift_rise, shift_fall, rep_rise;

  bubble_state_e       state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [AW-1:0]       bit_q, bit_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                rep_pend_q, rep_pend_d;
  logic                load_q, load_d;
  logic                under_q, under_d;
  logic                page_ok_q, page_ok_d;
  logic                slot_end, rd_start, rd_release, rd_avail;
  logic [CHANNELS-1:0] rd_data;

  always_ff @(posedge master_clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_sync_q <= '0;
      rep_sync_q   <= '0;
      shift_prev_q <= 1'b0;
      rep_prev_q   <= 1'b0;
    end else begin
      shift_sync_q <= {shift_sync_q[0], bubble_shift_enable};
      rep_sync_q   <= {rep_sync_q[0], replicator_enable};
      shift_prev_q <= shift_sync_q[1];
      rep_prev_q   <= rep_sync_q[1];
    end
  end

  assign shift_rise = shift_sync_q[1] && !shift_prev_q;
  assign shift_fall = !shift_sync_q[1] && shift_prev_q;
  assign rep_rise   = rep_sync_q[1] && !rep_prev_q;
  assign slot_end   = slot_q == SW'(SHIFT_DIV - 1);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    pos_d      = pos_q;
    bit_d      = bit_q;
    out_d      = out_q;
    rep_pend_d = rep_pend_q;
    load_d     = 1'b0;
    under_d    = under_q;
    page_ok_d  = page_ok_q;
    rd_start   = 1'b0;
    rd_release = 1'b0;

    if (state_q != StIdle) begin
      slot_d = slot_end ? '0 : slot_q + 1'b1;
      if (slot_end) begin
        pos_d = (pos_q == POS_W'(POSITIONS - 1)) ? '0 : pos_q + 1'b1;
      end
    end

    // Lane data updates one cycle after each slot boundary.
    if (slot_q == '0) begin
      out_d = (state_q == StReadout && page_ok_q) ? rd_data : '0;
    end

    unique case (state_q)
      StIdle: begin
        if (shift_rise && power_good) begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (rep_rise) begin
          rep_pend_d = 1'b1;
        end
        if (shift_fall) begin
          state_d    = StStop;
          rep_pend_d = 1'b0;
        end else if (slot_end && (rep_pend_q || rep_rise)) begin
          state_d    = StReadout;
          rep_pend_d = 1'b0;
          bit_d      = '0;
          rd_start   = 1'b1;
          page_ok_d  = rd_avail;
          if (!rd_avail) begin
            under_d = 1'b1;
          end
        end
      end
      StReadout: begin
        rep_pend_d = 1'b0;
        if (shift_fall) begin
          state_d    = StStop;
          rd_release = 1'b1;
        end else if (slot_end) begin
          if (bit_q == AW'(PAGE_BITS - 1)) begin
            state_d    = StShift;
            load_d     = 1'b1;
            rd_release = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (slot_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Power loss overrides everything: abort quietly and hold position.
    if (!power_good) begin
      state_d    = StIdle;
      slot_d     = '0;
      pos_d      = pos_q;
      out_d      = '0;
      load_d     = 1'b0;
      rep_pend_d = 1'b0;
      under_d    = under_q;
      rd_start   = 1'b0;
      rd_release = (state_q == StReadout);
    end
  end

  always_ff @(posedge master_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      slot_q     <= '0;
      pos_q      <= '0;
      bit_q      <= '0;
      out_q      <= '0;
      rep_pend_q <= 1'b0;
      load_q     <= 1'b0;
      under_q    <= 1'b0;
      page_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      pos_q      <= pos_d;
      bit_q      <= bit_d;
      out_q      <= out_d;
      rep_pend_q <= rep_pend_d;
      load_q     <= load_d;
      under_q    <= under_d;
      page_ok_q  <= page_ok_d;
    end
  end

  bubble_page_bank #(
    .CHANNELS  (CHANNELS),
    .PAGE_BITS (PAGE_BITS)
  ) u_page_bank (
    .clk_i             (master_clock),
    .rst_ni            (reset_n),
`ifdef BUBBLE_BOOTLOOP_EN
    .bootloop_enable_i (bootloop_enable),
`endif
    .host              (host),
    .rd_start_i        (rd_start),
    .rd_release_i      (rd_release),
    .rd_addr_i         (bit_q),
    .rd_avail_o        (rd_avail),
    .rd_data_o         (rd_data)
  );

  assign bubble_out = out_q;
  assign position   = pos_q;
  assign load_page  = load_q;
  assign busy       = (state_q == StReadout);
  assign underrun   = under_q;

endmodule
